ps2_key_encoder: RTL

Converts a raw PS/2 set-2 scancode byte stream into the 11-bit toggle-format `ps2_key` key-event word that the core's keyboard decoder consumes. Each event is the bit layout `{toggle, pressed, extended, code[7:0]}`. The block runs on the system clock between a PS/2 byte receiver and the core's key latches. It resolves E0/F0 prefixes and swallows the Pause sequence and protocol noise. Completed events are buffered in a small FIFO and paced so that no toggle is missed downstream.

---
 rtl/ps2_key_encoder_if.sv | 30 +++
 rtl/ps2_key_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_encoder_if
//  Description : Byte-stream input and key-event output bundle for the
//                PS/2 scancode-to-key-event encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_encoder_if;
    logic [7:0]  byte_in;     // received scancode byte
    logic        byte_valid;  // one-cycle strobe qualifying byte_in
    logic [10:0] ps2_key;     // {toggle, pressed, extended, code}
    logic        overflow;    // sticky event-drop flag

    // Byte source / key-event consumer side
    modport master (
        output byte_in,
        output byte_valid,
        input  ps2_key,
        input  overflow
    );

    // Encoder side
    modport slave (
        input  byte_in,
        input  byte_valid,
        output ps2_key,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_encoder
//  Description : Turns a PS/2 set-2 scancode byte stream into toggle-format
//                key events; resolves E0/F0 prefixes, swallows Pause and
//                protocol noise, buffers events and paces output toggles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_encoder #(
    parameter int GAP        = 4,   // min clocks between toggles, 1..255
    parameter int FIFO_DEPTH = 4    // power of two, 2..16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ps2_key_encoder_if.slave  bus
);

    localparam int              c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [7:0]      c_gap_load = 8'(GAP - 1);
    localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
    localparam logic [c_aw:0]   c_cnt_one  = (c_aw + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_skip, w_skip_nxt;
    logic            w_push;
    logic [9:0]      w_push_data;

    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wptr, r_rptr;
    logic [c_aw:0]   r_count;
    logic [7:0]      r_gap;
    logic [10:0]     r_key;
    logic            r_overflow;
    logic            w_pop, w_accept, w_fake_shift;

    // E0 12 / E0 59 are the fake-shift bytes some keyboards wrap around keys
    assign w_fake_shift = (bus.byte_in == 8'h12) || (bus.byte_in == 8'h59);

    // Decoder state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // Decoder next state and completed-event push
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_push      = 1'b0;
        w_push_data = 10'h000;
        if (bus.byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    case (bus.byte_in)
                        8'hE0: w_state_nxt = S_EXT;
                        8'hF0: w_state_nxt = S_BRK;
                        8'hE1: begin
                            w_state_nxt = S_PAUSE;
                            w_skip_nxt  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                        default: begin
                            w_push      = 1'b1;
                            w_push_data = {2'b10, bus.byte_in};
                        end
                    endcase
                end
                S_EXT: begin
                    if (bus.byte_in == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_push      = !w_fake_shift;
                        w_push_data = {2'b11, bus.byte_in};
                    end
                end
                S_BRK: begin
                    w_state_nxt = S_IDLE;
                    w_push      = 1'b1;
                    w_push_data = {2'b00, bus.byte_in};
                end
                S_EXT_BRK: begin
                    w_state_nxt = S_IDLE;
                    w_push      = !w_fake_shift;
                    w_push_data = {2'b01, bus.byte_in};
                end
                S_PAUSE: begin
                    // The Pause sequence body is skipped blindly; it yields a single make
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_state_nxt = S_IDLE;
                        w_push      = 1'b1;
                        w_push_data = {2'b11, 8'h77};
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A full FIFO still takes a push when the pacer drains an entry on the same edge
    assign w_pop    = (r_count != '0) && (r_gap == 8'd0);
    assign w_accept = w_push && ((r_count != c_depth) || w_pop);

    // Event storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // FIFO bookkeeping, output pacer and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_gap      <= 8'd0;
            r_key      <= 11'h000;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
                r_key  <= {~r_key[10], r_mem[r_rptr]};
                r_gap  <= c_gap_load;
            end else if (r_gap != 8'd0) begin
                r_gap <= r_gap - 8'd1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.ps2_key  = r_key;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
